// File: rtl/somador_serial.sv
// Bit-serial adder: one full-adder slice reused WIDTH times, LSB first,
// with a start/busy/done handshake and registered result outputs.
`timescale 1ns/1ps

module somador_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] ps;
  logic [WIDTH-1:0] ps_next;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             sb;
  logic             co;

  // Full-adder slice on the operand LSBs, and the partial sum with the new
  // bit shifted in at the top (written this way so WIDTH=1 needs no slice).
  always_comb begin
    sb      = ra[0] ^ rb[0] ^ c;
    co      = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
    ps_next = ps >> 1;
    ps_next[WIDTH-1] = sb;
  end

  // Control FSM and datapath; outputs only update on the completion edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      ps    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            c     <= cin;
            cnt   <= '0;
            ps    <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          ps  <= ps_next;
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          c   <= co;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            s     <= ps_next;
            cout  <= co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_somador_serial.sv
// Scoreboard bench for somador_serial: WIDTH=8 directed + random, WIDTH=2 exhaustive.
`timescale 1ns/1ps

module tb_somador_serial;

  typedef struct {
    logic [31:0] val;
    int          due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] s;
  logic       cout;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       cin2;
  logic       busy2;
  logic       done2;
  logic [1:0] s2;
  logic       cout2;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  exp_t q8[$];
  exp_t q2[$];

  somador_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .s(s), .cout(cout)
  );

  somador_serial #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .s(s2), .cout(cout2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Monitor for the 8-bit instance.
  logic [31:0] hold8 = 0;
  int          blen8 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold8 = 0;
      blen8 = 0;
    end else begin
      chk("busy_done_excl8", {31'd0, busy & done}, 0);
      if (busy) blen8++;
      else if (blen8 != 0) begin
        chk("busy_len8", blen8, 8);
        blen8 = 0;
      end
      if (done) begin
        if (q8.size() == 0) chk("spurious_done8", q8.size(), 1);
        else begin
          e = q8.pop_front();
          chk("sum8", {23'd0, cout, s}, e.val);
          chk("latency8", cyc, e.due);
          hold8 = e.val;
        end
      end else begin
        chk("hold8", {23'd0, cout, s}, hold8);
        if (q8.size() != 0 && cyc > q8[0].due) begin
          chk("missing_done8", {31'd0, done}, 1);
          void'(q8.pop_front());
        end
      end
    end
  end

  // Monitor for the 2-bit instance.
  logic [31:0] hold2 = 0;
  int          blen2 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold2 = 0;
      blen2 = 0;
    end else begin
      chk("busy_done_excl2", {31'd0, busy2 & done2}, 0);
      if (busy2) blen2++;
      else if (blen2 != 0) begin
        chk("busy_len2", blen2, 2);
        blen2 = 0;
      end
      if (done2) begin
        if (q2.size() == 0) chk("spurious_done2", q2.size(), 1);
        else begin
          e = q2.pop_front();
          chk("sum2", {29'd0, cout2, s2}, e.val);
          chk("latency2", cyc, e.due);
          hold2 = e.val;
        end
      end else begin
        chk("hold2", {29'd0, cout2, s2}, hold2);
        if (q2.size() != 0 && cyc > q2[0].due) begin
          chk("missing_done2", {31'd0, done2}, 1);
          void'(q2.pop_front());
        end
      end
    end
  end

  // Drive a request (called just after a clock edge); returns after the accepting edge.
  task automatic issue8(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    exp_t e;
    a = va; b = vb; cin = vc; start = 1'b1;
    e.val = 32'(va) + 32'(vb) + 32'(vc);
    e.due = cyc + 1 + 8;
    q8.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic issue2(input logic [1:0] va, input logic [1:0] vb, input logic vc);
    exp_t e;
    a2 = va; b2 = vb; cin2 = vc; start2 = 1'b1;
    e.val = 32'(va) + 32'(vb) + 32'(vc);
    e.due = cyc + 1 + 2;
    q2.push_back(e);
    @(posedge clk); #1;
    start2 = 1'b0;
  endtask

  // Advance from just after the accepting edge into the DONE cycle, then idle `gap` cycles.
  task automatic finish8(input int gap);
    repeat (8) @(posedge clk);
    #1;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s", {24'd0, s}, 0);
    chk("rst_cout", {31'd0, cout}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_s2", {29'd0, cout2, s2}, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("idle_busy", {31'd0, busy}, 0);
    end

    // Basic sums.
    issue8(8'h00, 8'h00, 1'b0); finish8(1);
    issue8(8'hFF, 8'h01, 1'b0); finish8(1);
    issue8(8'hA5, 8'h5A, 1'b1); finish8(1);

    // Input isolation: operands and start change mid-run.
    issue8(8'h12, 8'h34, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    @(posedge clk); #1;

    // Reset in RUN cycle 4: result discarded, outputs clear immediately.
    issue8(8'h80, 8'h80, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    q8.delete();
    #1;
    chk("midrst_s", {24'd0, s}, 0);
    chk("midrst_cout", {31'd0, cout}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("postrst_s", {23'd0, cout, s}, 0);

    // Back-to-back: second start held during the DONE cycle.
    issue8(8'h01, 8'h02, 1'b0); finish8(0);
    issue8(8'h7F, 8'h01, 1'b0); finish8(1);

    // Random operands with random gaps (gap 0 = back-to-back).
    for (int i = 0; i < 40; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom));
      finish8(int'($urandom_range(0, 2)));
    end
    repeat (3) @(posedge clk);
    #1;

    // Exhaustive WIDTH=2.
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          issue2(2'(ia), 2'(ib), 1'(ic));
          repeat (2) @(posedge clk);
          #1;
          if (ic == 1) begin @(posedge clk); #1; end
        end

    repeat (5) @(posedge clk);
    #1;
    chk("q8_drained", q8.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
